// File: rtl/rr_arbiter8x3.sv
// Round-robin arbiter for 8 requesters with a one-hot grant, a 3-bit encoded owner index,
// and a hold-limit timeout so that one requester cannot keep the resource forever.
//
// state | meaning
// IDLE  | no owner; gv=0, gnt=0; d keeps the last owner
// GRANT | owner d holds the resource; busy_cnt counts held cycles
module rr_arbiter8x3 #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i,
  output logic [N-1:0] gnt,
  output logic [2:0]   d,
  output logic         gv,
  output logic [7:0]   busy_cnt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]   state;
  logic [2:0]   ptr;
  logic [N-1:0] others;
  logic [N-1:0] cand;
  logic [2:0]   base;
  logic [2:0]   idx;
  logic [2:0]   win;
  logic         found;
  logic         own_req;
  logic         release_own;
  logic         timeout;

  always_comb begin
    own_req     = i[d];
    others      = i & ~(N'(1) << d);
    release_own = (state == GRANT) && !own_req;
    timeout     = (state == GRANT) && own_req && (busy_cnt >= 8'(MAX_HOLD)) && (|others);
    base        = (state == IDLE) ? ptr : d + 3'd1;
    // On timeout the current owner is masked out so it must wait for its next turn.
    cand        = timeout ? others : i;
    found       = 1'b0;
    win         = 3'd0;
    idx         = 3'd0;
    for (int k = 0; k < N; k++) begin
      idx = base + k[2:0];
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      gnt      <= '0;
      d        <= 3'd0;
      gv       <= 1'b0;
      busy_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt      <= N'(1) << win;
            d        <= win;
            gv       <= 1'b1;
            busy_cnt <= 8'd1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (release_own || timeout) begin
            ptr <= d + 3'd1;
            if (found) begin
              gnt      <= N'(1) << win;
              d        <= win;
              busy_cnt <= 8'd1;
            end else begin
              gnt      <= '0;
              gv       <= 1'b0;
              busy_cnt <= 8'd0;
              state    <= IDLE;
            end
          end else if (busy_cnt != 8'hFF) begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8x3.sv
// Self-checking bench for rr_arbiter8x3: a behavioural model feeds a scoreboard queue,
// plus directed constant checks and randomized invariant / starvation checks.
module tb_rr_arbiter8x3;

  localparam int MAX_HOLD = 16;
  localparam int BOUND    = 7 * MAX_HOLD + 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i   = 8'h00;
  logic [7:0] gnt;
  logic [2:0] d;
  logic       gv;
  logic [7:0] busy_cnt;

  always #5 clk = ~clk;

  rr_arbiter8x3 #(.N(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .i        (i),
    .gnt      (gnt),
    .d        (d),
    .gv       (gv),
    .busy_cnt (busy_cnt)
  );

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] d;
    logic       gv;
    logic [7:0] busy;
  } obs_t;

  obs_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_gnt;
  logic [2:0] m_d;
  logic [2:0] m_ptr;
  logic       m_gv;
  logic [7:0] m_busy;

  function automatic obs_t cur();
    obs_t o;
    o.gnt  = gnt;
    o.d    = d;
    o.gv   = gv;
    o.busy = busy_cnt;
    return o;
  endfunction

  task automatic model_reset();
    m_gnt  = 8'h00;
    m_d    = 3'd0;
    m_ptr  = 3'd0;
    m_gv   = 1'b0;
    m_busy = 8'd0;
  endtask

  task automatic model_step(input logic [7:0] req);
    logic [7:0] pool;
    logic [7:0] rivals;
    obs_t       e;
    int         start;
    int         w;
    bit         arb;
    arb    = 1'b0;
    pool   = req;
    start  = int'(m_ptr);
    w      = 0;
    rivals = req;
    rivals[m_d] = 1'b0;
    if (m_gv) begin
      if (!req[m_d] || (int'(m_busy) >= MAX_HOLD && rivals != 8'h00)) begin
        m_ptr = 3'((int'(m_d) + 1) % 8);
        start = int'(m_ptr);
        pool  = rivals;
        arb   = 1'b1;
        if (rivals == 8'h00) begin
          m_gv   = 1'b0;
          m_gnt  = 8'h00;
          m_busy = 8'd0;
        end
      end else if (m_busy < 8'd255) begin
        m_busy = m_busy + 8'd1;
      end
    end else begin
      arb = 1'b1;
    end
    if (arb && pool != 8'h00) begin
      for (int s = 0; s < 8; s++) begin
        w = (start + s) % 8;
        if (pool[w]) break;
      end
      m_gnt  = 8'(1 << w);
      m_d    = 3'(w);
      m_gv   = 1'b1;
      m_busy = 8'd1;
    end
    e.gnt  = m_gnt;
    e.d    = m_d;
    e.gv   = m_gv;
    e.busy = m_busy;
    sb_q.push_back(e);
  endtask

  task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got gnt=%h d=%0d gv=%b busy=%0d exp gnt=%h d=%0d gv=%b busy=%0d",
             tag, got.gnt, got.d, got.gv, got.busy, exp.gnt, exp.d, exp.gv, exp.busy);
    end
  endtask

  task automatic expect_now(input string tag, input logic [7:0] g, input logic [2:0] dd,
                            input logic v, input logic [7:0] b);
    obs_t e;
    e.gnt  = g;
    e.d    = dd;
    e.gv   = v;
    e.busy = b;
    check_obs(tag, cur(), e);
  endtask

  task automatic cycle(input logic [7:0] req);
    obs_t e;
    @(negedge clk);
    i = req;
    model_step(req);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty got size=0 exp size=1");
    end else begin
      e = sb_q.pop_front();
      check_obs("sb", cur(), e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i   = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitc[8];
    int worst;
    worst = 0;
    model_reset();
    rst = 1'b1;
    i   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    expect_now("reset", 8'h00, 3'd0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // single requester, counting without timeout
    cycle(8'h01);
    expect_now("t1_first", 8'h01, 3'd0, 1'b1, 8'd1);
    repeat (4) cycle(8'h01);
    expect_now("t1_busy5", 8'h01, 3'd0, 1'b1, 8'd5);
    cycle(8'h00);
    expect_now("t1_idle", 8'h00, 3'd0, 1'b0, 8'd0);

    // full rotation with release after two cycles
    do_reset();
    cycle(8'hFF);
    expect_now("t2_start", 8'h01, 3'd0, 1'b1, 8'd1);
    for (int k = 0; k < 8; k++) begin
      int nx;
      logic [7:0] r;
      nx = (k + 1) % 8;
      r  = 8'hFF;
      r[k] = 1'b0;
      cycle(8'hFF);
      cycle(r);
      expect_now("t2_rot", 8'(1 << nx), 3'(nx), 1'b1, 8'd1);
    end

    // hold-limit timeout and round-robin regain
    do_reset();
    cycle(8'h04);
    repeat (15) cycle(8'h24);
    expect_now("t3_hold16", 8'h04, 3'd2, 1'b1, 8'd16);
    cycle(8'h24);
    expect_now("t3_timeout", 8'h20, 3'd5, 1'b1, 8'd1);
    repeat (3) cycle(8'h24);
    expect_now("t3_wait", 8'h20, 3'd5, 1'b1, 8'd4);
    cycle(8'h04);
    expect_now("t3_regain", 8'h04, 3'd2, 1'b1, 8'd1);

    // saturation while alone, then timeout on first competing request
    do_reset();
    repeat (260) cycle(8'h01);
    expect_now("sat255", 8'h01, 3'd0, 1'b1, 8'd255);
    cycle(8'h03);
    expect_now("sat_timeout", 8'h02, 3'd1, 1'b1, 8'd1);

    // pointer wrap from 7, and release to idle keeps d
    do_reset();
    cycle(8'h80);
    expect_now("t4_own7", 8'h80, 3'd7, 1'b1, 8'd1);
    cycle(8'h04);
    expect_now("t4_wrap", 8'h04, 3'd2, 1'b1, 8'd1);
    do_reset();
    cycle(8'h80);
    cycle(8'h00);
    expect_now("t4_idle", 8'h00, 3'd7, 1'b0, 8'd0);

    // asynchronous reset mid-grant
    do_reset();
    cycle(8'h10);
    cycle(8'h10);
    expect_now("t5_own4", 8'h10, 3'd4, 1'b1, 8'd2);
    #2;
    rst = 1'b1;
    #1;
    expect_now("t5_async", 8'h00, 3'd0, 1'b0, 8'd0);
    model_reset();
    sb_q.delete();
    @(negedge clk);
    i   = 8'h00;
    rst = 1'b0;
    cycle(8'h11);
    expect_now("t5_after", 8'h01, 3'd0, 1'b1, 8'd1);

    // randomized traffic with owner bias so timeouts occur
    do_reset();
    for (int k = 0; k < 8; k++) waitc[k] = 0;
    for (int n = 0; n < 10000; n++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if (m_gv && $urandom_range(0, 15) != 0) r[m_d] = 1'b1;
      cycle(r);
      checks++;
      assert (gv ? $onehot(gnt) : (gnt == 8'h00)) else begin
        errors++;
        $error("FAIL onehot got gnt=%h gv=%b exp onehot-or-zero", gnt, gv);
      end
      checks++;
      assert (!gv || gnt == 8'(1 << d)) else begin
        errors++;
        $error("FAIL encode got d=%0d gnt=%h exp gnt=%h", d, gnt, 8'(1 << d));
      end
      for (int k = 0; k < 8; k++) begin
        if (r[k] && !(gv && gnt[k])) waitc[k]++;
        else waitc[k] = 0;
        if (waitc[k] > worst) worst = waitc[k];
      end
    end
    checks++;
    assert (worst <= BOUND) else begin
      errors++;
      $error("FAIL starvation got wait=%0d exp max=%0d", worst, BOUND);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
